// File: rtl/demux_route_scheduler.sv
// Request FIFO plus IDLE/SETUP/STROBE sequencer for a 1-to-3 byte demux.
// Define SCHED_COUNT_EN to add the per-destination completion counters CNT1..CNT3.
module demux_route_scheduler #(
  parameter int DEPTH        = 4,
  parameter int SETUP_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [7:0] REQ_DATA,
  input  logic [1:0] REQ_DEST,
  output logic [7:0] DMX_I,
  output logic [1:0] DMX_S,
  output logic [2:0] LOAD,
  input  logic [2:0] ACK,
  output logic       BUSY,
`ifdef SCHED_COUNT_EN
  output logic [7:0] CNT1,
  output logic [7:0] CNT2,
  output logic [7:0] CNT3,
`endif
  output logic       ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(SETUP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;

  state_t        state, state_nxt;
  logic [9:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [SW-1:0] setup_cnt;
  logic          push, pop, drop, ack_hit, setup_done;
  logic [1:0]    cur_dest, dest_nxt;
  logic [7:0]    cur_data, data_nxt;
  logic [7:0]    dmx_i_nxt;
  logic [1:0]    dmx_s_nxt;
  logic [2:0]    load_nxt;

  function automatic logic [2:0] dest_onehot(input logic [1:0] dest);
    case (dest)
      2'b01:   return 3'b001;
      2'b10:   return 3'b010;
      2'b11:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Illegal destination code is consumed from the bus but never enters the FIFO.
  assign push       = REQ_VALID && REQ_READY && (REQ_DEST != 2'b00);
  assign drop       = REQ_VALID && REQ_READY && (REQ_DEST == 2'b00);
  assign pop        = (state == IDLE) && (count != '0);
  assign ack_hit    = (state == STROBE) && |(ACK & dest_onehot(cur_dest));
  assign setup_done = (setup_cnt == SW'(SETUP_CYCLES - 1));
  assign dest_nxt   = pop ? fifo_mem[rd_ptr][9:8] : cur_dest;
  assign data_nxt   = pop ? fifo_mem[rd_ptr][7:0] : cur_data;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= {REQ_DEST, REQ_DATA};
    if (pop) begin
      cur_dest <= fifo_mem[rd_ptr][9:8];
      cur_data <= fifo_mem[rd_ptr][7:0];
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      setup_cnt <= '0;
      REQ_READY <= 1'b1;
      BUSY      <= 1'b0;
      ERR       <= 1'b0;
      DMX_I     <= 8'h00;
      DMX_S     <= 2'b00;
      LOAD      <= 3'b000;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (pop) setup_cnt <= '0;
      else if (state == SETUP && !setup_done) setup_cnt <= setup_cnt + SW'(1);
      REQ_READY <= (count_nxt != CW'(DEPTH));
      BUSY      <= (state_nxt != IDLE) || (count_nxt != '0);
      ERR       <= drop;
      DMX_I     <= dmx_i_nxt;
      DMX_S     <= dmx_s_nxt;
      LOAD      <= load_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = SETUP;
      SETUP:   if (setup_done) state_nxt = STROBE;
      STROBE:  if (ack_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dmx_s_nxt = 2'b00;
    dmx_i_nxt = 8'h00;
    load_nxt  = 3'b000;
    if (state_nxt != IDLE) begin
      dmx_s_nxt = dest_nxt;
      dmx_i_nxt = data_nxt;
      if (state_nxt == STROBE) load_nxt = dest_onehot(dest_nxt);
    end
  end

`ifdef SCHED_COUNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      CNT1 <= 8'h00;
      CNT2 <= 8'h00;
      CNT3 <= 8'h00;
    end else if (ack_hit) begin
      case (cur_dest)
        2'b01:   CNT1 <= CNT1 + 8'd1;
        2'b10:   CNT2 <= CNT2 + 8'd1;
        2'b11:   CNT3 <= CNT3 + 8'd1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_demux_route_scheduler.sv
// Directed bench for demux_route_scheduler: transaction-level model checked every
// cycle, plus hand-computed checkpoints. Honors SCHED_COUNT_EN when defined.
module tb_demux_route_scheduler;

  localparam int DEPTH = 4;
  localparam int SETUP = 1;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic [7:0] REQ_DATA;
  logic [1:0] REQ_DEST;
  logic [7:0] DMX_I;
  logic [1:0] DMX_S;
  logic [2:0] LOAD;
  logic [2:0] ACK;
  logic       BUSY;
  logic       ERR;
`ifdef SCHED_COUNT_EN
  logic [7:0] CNT1, CNT2, CNT3;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  demux_route_scheduler #(.DEPTH(DEPTH), .SETUP_CYCLES(SETUP)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_DATA(REQ_DATA), .REQ_DEST(REQ_DEST), .DMX_I(DMX_I), .DMX_S(DMX_S),
    .LOAD(LOAD), .ACK(ACK), .BUSY(BUSY),
`ifdef SCHED_COUNT_EN
    .CNT1(CNT1), .CNT2(CNT2), .CNT3(CNT3),
`endif
    .ERR(ERR)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Transaction-level model: a queue of pending requests and one in-flight
  // transfer whose age counts edges since it left the queue.
  typedef struct {
    logic [1:0] dest;
    logic [7:0] data;
  } req_t;

  req_t       mq[$];
  req_t       mr;
  bit         started = 0;
  bit         m_fl    = 0;
  int         m_age   = 0;
  logic [1:0] m_dest  = 0;
  logic [7:0] m_data  = 0;
  bit         m_ready = 1;
  bit         m_err   = 0;
  bit         m_acc;
  int         m_cnt [4];

  always @(posedge CLK) begin
    if (RST) begin
      mq.delete();
      m_fl    = 0;
      m_age   = 0;
      m_ready = 1;
      m_err   = 0;
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
      started = 1;
    end else begin
      m_acc = REQ_VALID && m_ready;
      if (m_fl && m_age > SETUP && ACK[int'(m_dest) - 1]) begin
        m_fl = 0;
        m_cnt[m_dest] = (m_cnt[m_dest] + 1) % 256;
      end else if (m_fl) begin
        m_age++;
      end else if (mq.size() > 0) begin
        mr     = mq.pop_front();
        m_dest = mr.dest;
        m_data = mr.data;
        m_fl   = 1;
        m_age  = 1;
      end
      if (m_acc && REQ_DEST != 2'b00) begin
        mr.dest = REQ_DEST;
        mr.data = REQ_DATA;
        mq.push_back(mr);
      end
      m_err   = m_acc && (REQ_DEST == 2'b00);
      m_ready = mq.size() < DEPTH;
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      check("m_dmx_s", DMX_S, m_fl ? m_dest : 2'b00);
      check("m_dmx_i", DMX_I, m_fl ? m_data : 8'h00);
      check("m_load", LOAD, (m_fl && m_age > SETUP) ? (3'b001 << (int'(m_dest) - 1)) : 3'b000);
      check("m_busy", BUSY, m_fl || mq.size() > 0);
      check("m_ready", REQ_READY, m_ready);
      check("m_err", ERR, m_err);
`ifdef SCHED_COUNT_EN
      check("m_cnt1", CNT1, m_cnt[1]);
      check("m_cnt2", CNT2, m_cnt[2]);
      check("m_cnt3", CNT3, m_cnt[3]);
`endif
    end
  end

  initial begin
    int w;
    RST = 1'b1; REQ_VALID = 1'b0; REQ_DATA = 8'h00; REQ_DEST = 2'b00; ACK = 3'b000;

    // Reset held two cycles
    tick(); tick();
    check("t1_s", DMX_S, 2'b00);
    check("t1_i", DMX_I, 8'h00);
    check("t1_load", LOAD, 3'b000);
    check("t1_ready", REQ_READY, 1'b1);
    check("t1_busy", BUSY, 1'b0);
    check("t1_err", ERR, 1'b0);
    RST = 1'b0;
    tick();

    // Single transfer to Q1
    REQ_VALID = 1'b1; REQ_DATA = 8'h05; REQ_DEST = 2'b01;
    tick();                                   // E0
    REQ_VALID = 1'b0;
    check("t2_busy_e0", BUSY, 1'b1);
    tick();                                   // E1
    check("t2_s_e1", DMX_S, 2'b01);
    check("t2_i_e1", DMX_I, 8'h05);
    check("t2_load_e1", LOAD, 3'b000);
    tick();                                   // E2
    check("t2_load_e2", LOAD, 3'b001);
    tick();                                   // E3
    check("t2_load_e3", LOAD, 3'b001);
    ACK = 3'b001;
    tick();                                   // E4
    ACK = 3'b000;
    check("t2_load_e4", LOAD, 3'b000);
    check("t2_s_e4", DMX_S, 2'b00);
    check("t2_busy_e4", BUSY, 1'b0);
`ifdef SCHED_COUNT_EN
    check("t2_cnt1", CNT1, 8'd1);
`endif
    tick();

    // Fill to capacity with dest=11, then drain
    REQ_VALID = 1'b1; REQ_DEST = 2'b11;
    for (int i = 0; i < 6; i++) begin
      REQ_DATA = 8'h30 + 8'(i);
      tick();
      if (i == 3) check("t3_ready_e3", REQ_READY, 1'b1);
      if (i == 4) check("t3_ready_e4", REQ_READY, 1'b0);
    end
    REQ_VALID = 1'b0;
    for (int n = 0; n < 5; n++) begin
      w = 0;
      while (LOAD !== 3'b100 && w < 10) begin
        tick();
        w++;
      end
      check("t3_load", LOAD, 3'b100);
      check("t3_data", DMX_I, 8'h30 + 8'(n));
      ACK = 3'b100;
      tick();
      ACK = 3'b000;
      check("t3_load_off", LOAD, 3'b000);
    end
    tick();
    check("t3_busy_end", BUSY, 1'b0);
    check("t3_ready_end", REQ_READY, 1'b1);

    // Illegal destination dropped
    REQ_VALID = 1'b1; REQ_DATA = 8'h0F; REQ_DEST = 2'b00;
    tick();
    REQ_VALID = 1'b0;
    check("t4_err", ERR, 1'b1);
    check("t4_load", LOAD, 3'b000);
    check("t4_s", DMX_S, 2'b00);
    check("t4_busy", BUSY, 1'b0);
    tick();
    check("t4_err_off", ERR, 1'b0);

    // Foreign ACKs ignored in STROBE
    REQ_VALID = 1'b1; REQ_DATA = 8'h5A; REQ_DEST = 2'b10;
    tick();
    REQ_VALID = 1'b0;
    tick(); tick();
    check("t5_load", LOAD, 3'b010);
    ACK = 3'b001;
    tick();
    check("t5_load_ack1", LOAD, 3'b010);
    ACK = 3'b100;
    tick();
    check("t5_load_ack3", LOAD, 3'b010);
    ACK = 3'b010;
    tick();
    ACK = 3'b000;
    check("t5_load_done", LOAD, 3'b000);
    check("t5_s_done", DMX_S, 2'b00);
    tick();

    // Reset during STROBE with three queued
    REQ_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      REQ_DATA = 8'h11 * 8'(i + 1);
      REQ_DEST = 2'((i % 3) + 1);
      tick();
    end
    REQ_VALID = 1'b0;
    check("t6_load_pre", LOAD, 3'b001);
    check("t6_busy_pre", BUSY, 1'b1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t6_load", LOAD, 3'b000);
    check("t6_busy", BUSY, 1'b0);
    check("t6_ready", REQ_READY, 1'b1);
    check("t6_s", DMX_S, 2'b00);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t6_load_quiet", LOAD, 3'b000);
    end
`ifdef SCHED_COUNT_EN
    check("t6_cnt1", CNT1, 8'd0);
    check("t6_cnt3", CNT3, 8'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
